// File: rtl/imem_fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, reads the async ROM and queues {pc, instr} for decode.
// Optional starvation counter enabled by defining IFB_STALL_STAT_EN.
module imem_fetch_buffer #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              ROM_AW   = 11,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             redirect_valid,
  input  logic [ADDR_W-1:0]                redirect_pc,
  output logic [ROM_AW-1:0]                rom_addr,
  input  logic [DATA_W-1:0]                rom_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_instr,
  output logic [ADDR_W-1:0]                out_pc,
  output logic [$clog2(DEPTH+1)-1:0]       count
`ifdef IFB_STALL_STAT_EN
  ,
  output logic [31:0]                      starve_cnt
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

  logic [ADDR_W-1:0] fetch_pc_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic              unused_pc_bits_s;

  logic [ADDR_W-1:0] pc_mem_r    [DEPTH];
  logic [DATA_W-1:0] instr_mem_r [DEPTH];

  assign unused_pc_bits_s = ^redirect_pc[1:0];

  assign rom_addr  = fetch_pc_r[ROM_AW+1:2];
  assign out_valid = (count_r != '0) && !redirect_valid;
  assign out_instr = instr_mem_r[rd_ptr_r];
  assign out_pc    = pc_mem_r[rd_ptr_r];
  assign count     = count_r;

  // Handshake decode; a full buffer still accepts a word when the head leaves the same edge.
  always_comb begin
    pop_s       = out_valid && out_ready;
    push_s      = !redirect_valid && ((count_r < FULL_CNT) || pop_s);
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Fetch PC, pointers and occupancy; redirect flushes and outranks push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r <= RESET_PC;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_r <= {redirect_pc[ADDR_W-1:2], 2'b00};
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
    end else begin
      if (push_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
        wr_ptr_r   <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
    end
  end

  // Entry storage is deliberately not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= fetch_pc_r;
      instr_mem_r[wr_ptr_r] <= rom_data;
    end
  end

`ifdef IFB_STALL_STAT_EN
  // Saturating count of cycles where decode wanted an instruction but none was offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 32'd0;
    end else if (out_ready && !out_valid && (starve_cnt != 32'hFFFF_FFFF)) begin
      starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_buffer.sv
// Directed bench for imem_fetch_buffer; ROM model returns 0x1000_0000 + word address.
module tb_imem_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [10:0] rom_addr;
  logic [31:0] rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;
`ifdef IFB_STALL_STAT_EN
  logic [31:0] starve_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  imem_fetch_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
`ifdef IFB_STALL_STAT_EN
    ,
    .starve_cnt     (starve_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rom_data = 32'h1000_0000 + {21'd0, rom_addr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle well clear of it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_rom_addr", {53'd0, rom_addr}, 64'd0);
`ifdef IFB_STALL_STAT_EN
    chk("rst_starve", {32'd0, starve_cnt}, 64'd0);
`endif

    // Streaming: one instruction per cycle from the first edge after reset.
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_pc", {32'd0, out_pc}, {32'd0, 32'h0040_0000 + 32'(4 * k)});
      chk("stream_instr", {32'd0, out_instr}, {32'd0, 32'h1000_0000 + 32'(k)});
      chk("stream_count", {61'd0, count}, 64'd1);
    end

    // Fill with decode stalled.
    rst = 1'b1; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk("fill_count", {61'd0, count}, (i < 4) ? 64'(i) : 64'd4);
    end
    chk("full_rom_addr", {53'd0, rom_addr}, 64'd4);

    // Single-cycle pop while full: push lands on the same edge.
    out_ready = 1'b1;
    #1;
    chk("full_head_pc", {32'd0, out_pc}, 64'h0040_0000);
    cyc();
    out_ready = 1'b0;
    #1;
    chk("pp_count", {61'd0, count}, 64'd4);
    chk("pp_rom_addr", {53'd0, rom_addr}, 64'd5);

    // Drain in order, then streaming continues while full.
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk("drain_pc", {32'd0, out_pc}, {32'd0, 32'h0040_0000 + 32'(4 * k)});
      chk("drain_instr", {32'd0, out_instr}, {32'd0, 32'h1000_0000 + 32'(k)});
      cyc();
    end
    chk("drain_count", {61'd0, count}, 64'd4);

    // Redirect with three entries buffered.
    rst = 1'b1; out_ready = 1'b0;
    cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_redir_count", {61'd0, count}, 64'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0103; out_ready = 1'b1;
    #1;
    chk("redir_valid_same", {63'd0, out_valid}, 64'd0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("redir_count", {61'd0, count}, 64'd0);
    chk("redir_valid_next", {63'd0, out_valid}, 64'd0);
    chk("redir_rom_addr", {53'd0, rom_addr}, 64'h40);
`ifdef IFB_STALL_STAT_EN
    chk("starve_one", {32'd0, starve_cnt}, 64'd1);
`endif
    cyc();
    chk("redir_first_valid", {63'd0, out_valid}, 64'd1);
    chk("redir_first_pc", {32'd0, out_pc}, 64'h0040_0100);
    chk("redir_first_instr", {32'd0, out_instr}, 64'h1000_0040);
`ifdef IFB_STALL_STAT_EN
    chk("starve_two", {32'd0, starve_cnt}, 64'd2);
`endif
    cyc();
    chk("redir_second_pc", {32'd0, out_pc}, 64'h0040_0104);
`ifdef IFB_STALL_STAT_EN
    chk("starve_hold", {32'd0, starve_cnt}, 64'd2);
`endif

    // Redirect near the top of the address space; PC wraps to zero.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("wrap_pc0", {32'd0, out_pc}, 64'hFFFF_FFF8);
    chk("wrap_instr0", {32'd0, out_instr}, 64'h1000_07FE);
    cyc();
    chk("wrap_pc1", {32'd0, out_pc}, 64'hFFFF_FFFC);
    chk("wrap_instr1", {32'd0, out_instr}, 64'h1000_07FF);
    cyc();
    chk("wrap_pc2", {32'd0, out_pc}, 64'h0000_0000);
    chk("wrap_instr2", {32'd0, out_instr}, 64'h1000_0000);

    // Reset colliding with a redirect while three entries are held.
    out_ready = 1'b0;
    cyc(); cyc();
    chk("pre_rst_count", {61'd0, count}, 64'd3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1234;
    cyc();
    redirect_valid = 1'b0;
    #1;
    chk("rst_redir_count", {61'd0, count}, 64'd0);
    chk("rst_redir_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_redir_rom_addr", {53'd0, rom_addr}, 64'd0);
`ifdef IFB_STALL_STAT_EN
    chk("rst_redir_starve", {32'd0, starve_cnt}, 64'd0);
`endif
    rst = 1'b0; out_ready = 1'b1;
    cyc();
    chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
    chk("post_rst_pc", {32'd0, out_pc}, 64'h0040_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
